core_seq_ctrl: RTL
==================

# core_seq_ctrl

Core-side sequencer that consumes the pause and stack-overflow interrupt controls produced by the core-control map block, and feeds back the halt report and PC it needs. It sits between that map block and the core fetch/PC logic. It drains the pipeline before pausing, or before vectoring to the overflow ISR. It saves and restores the PC around the ISR and reports HLT instructions. All outputs are registered or decoded from registered state.

## Interface
- ISR_VECTOR, 15'h0008, word address loaded into PC on interrupt entry (SW byte address 0x0010)
- DRAIN_MAX, 15, maximum drain cycles before forced progress (4-bit counter, 1..15)

- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset; synchronous and active-high
- i_doPause  in  1  pause request (level) from core-control block
- i_intOVF  in  1  stack-overflow interrupt (level) from core-control block
- i_haltInstr  in  1  HLT decoded in execute this cycle
- i_retI  in  1  return-from-interrupt decoded in execute this cycle
- i_pipeEmpty  in  1  no instruction in flight past fetch
- i_pcCur  in  15  PC word address of next instruction to execute
- o_stall  out  1  freeze fetch/PC advance
- o_flush  out  1  discard fetched-but-unexecuted instructions (1-cycle pulse)
- o_pcLoad  out  1  load o_pcLoadVal into PC (1-cycle pulse)
- o_pcLoadVal  out  15  PC load value
- o_reportHLT  out  1  HLT seen (1-cycle pulse), drives the core-control block's HLT report
- o_inIsr  out  1  ISR in progress
- o_savedPC  out  15  PC captured at ISR entry
- o_drainErr  out  1  sticky: a drain hit DRAIN_MAX without i_pipeEmpty

## Operation
- States: RUN, DRAIN_PAUSE, PAUSED, DRAIN_INT, VECTOR.
- RUN, priority high to low:
  - i_haltInstr: pulse o_reportHLT, go to DRAIN_PAUSE.
  - i_doPause: go to DRAIN_PAUSE.
  - i_intOVF & ~o_inIsr: go to DRAIN_INT.
  - i_retI & o_inIsr: pulse o_pcLoad with o_pcLoadVal = o_savedPC, pulse o_flush, clear o_inIsr.
  - Otherwise: stay.
- i_retI with o_inIsr = 0 is ignored; no load occurs.
- DRAIN_PAUSE / DRAIN_INT:
  - o_stall = 1. The drain counter clears on entry and increments each cycle.
  - Exit when i_pipeEmpty is sampled high. Minimum dwell is 1 cycle.
  - If the counter reaches DRAIN_MAX first: set o_drainErr, then exit anyway.
  - DRAIN_PAUSE exits to PAUSED; DRAIN_INT exits to VECTOR.
- PAUSED: o_stall = 1. Go to RUN when i_doPause is sampled low. o_inIsr and o_savedPC are preserved, so pause inside an ISR is legal.
- VECTOR (1 cycle):
  - o_savedPC <= i_pcCur; o_inIsr <= 1.
  - o_pcLoad pulse, o_pcLoadVal = ISR_VECTOR, o_flush pulse.
  - Next state RUN.
- i_intOVF is level-sensitive. It is masked while o_inIsr = 1. If it is still high after the return, the ISR re-enters.
- o_drainErr clears only on reset.

## Timing
- Reset (i_rst high at an edge): state RUN. All outputs 0: o_stall, o_flush, o_pcLoad, o_pcLoadVal, o_reportHLT, o_inIsr, o_savedPC, o_drainErr. Drain counter 0.
- Reset mid-operation from any state returns to RUN next cycle and drops a pending ISR.
- A trigger sampled at edge N produces its response in the cycle after edge N:
  - state entry, o_stall high, o_reportHLT pulse, RETI o_pcLoad/o_flush.
- Interrupt entry with pipe already empty:
  - edge N: intOVF sampled, go to DRAIN_INT;
  - edge N+1: go to VECTOR;
  - edge N+2: o_pcLoad/o_flush are high in the cycle after edge N+2;
  - o_stall stays high through that VECTOR output cycle.
- HLT: o_reportHLT in cycle N+1 lets the core-control block set pause at edge N+1. The minimum 1-cycle drain guarantees i_doPause = 1 before PAUSED evaluates it.
- Pause release: i_doPause low at edge M → o_stall low from the cycle after edge M.
- Simultaneous i_doPause and i_intOVF: pause wins. The interrupt is taken on return to RUN if still asserted.
- Simultaneous i_retI and i_intOVF inside an ISR: RETI executes; the interrupt is taken on the next evaluation.
- o_pcLoad and o_flush are never high for two consecutive cycles.

## Test plan
- Reset with all inputs 0 → every output 0, state RUN.
- i_intOVF = 1, i_pipeEmpty = 1, i_pcCur = 0x0123 → o_pcLoad = 1 with o_pcLoadVal = 0x0008 two cycles after the sampling edge. Then o_savedPC = 0x0123, o_inIsr = 1. A further i_intOVF is ignored.
- In ISR, pulse i_retI → next cycle o_pcLoad = 1, o_pcLoadVal = 0x0123, o_flush = 1, o_inIsr = 0. With i_intOVF still high → re-entry to 0x0008.
- i_haltInstr pulse, then i_doPause = 1 the following cycle with i_pipeEmpty delayed 3 cycles → o_reportHLT a single pulse, o_stall held. Drop i_doPause → o_stall = 0 one cycle later.
- i_doPause = 1 with i_pipeEmpty held 0 → after 15 drain cycles o_drainErr = 1 and state is PAUSED. o_drainErr stays 1 until i_rst.
- i_doPause and i_intOVF raised together → PAUSED first. After release, interrupt entry with o_savedPC = i_pcCur at entry.

Source files
------------

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: core-side sequencer between the core-control map block and
// the fetch/PC logic. Drains the pipeline before pausing or before vectoring
// to the stack-overflow ISR, saves/restores the PC around the ISR and reports
// HLT instructions back to the core-control block.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_doPause           pause request (level)
//   i_intOVF            stack-overflow interrupt (level), masked while in ISR
//   i_haltInstr         HLT decoded in execute
//   i_retI              return-from-interrupt decoded in execute
//   i_pipeEmpty         nothing in flight past fetch
//   i_pcCur             PC word address of next instruction to execute
//   o_stall             freeze fetch/PC advance
//   o_flush             discard fetched instructions (pulse)
//   o_pcLoad            load o_pcLoadVal into PC (pulse)
//   o_pcLoadVal         PC load value
//   o_reportHLT         HLT seen (pulse)
//   o_inIsr             ISR in progress
//   o_savedPC           PC captured at ISR entry
//   o_drainErr          sticky: a drain timed out without i_pipeEmpty
module core_seq_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_doPause,
  input  logic        i_intOVF,
  input  logic        i_haltInstr,
  input  logic        i_retI,
  input  logic        i_pipeEmpty,
  input  logic [14:0] i_pcCur,
  output logic        o_stall,
  output logic        o_flush,
  output logic        o_pcLoad,
  output logic [14:0] o_pcLoadVal,
  output logic        o_reportHLT,
  output logic        o_inIsr,
  output logic [14:0] o_savedPC,
  output logic        o_drainErr
);

  localparam int unsigned PC_W      = 15;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DRAIN_MAX = 15;
  localparam logic [PC_W-1:0] ISR_VECTOR = 15'h0008;

  typedef enum logic [2:0] {
    RUN         = 3'd0,
    DRAIN_PAUSE = 3'd1,
    PAUSED      = 3'd2,
    DRAIN_INT   = 3'd3,
    VECTOR      = 3'd4
  } state_t;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  drainCnt, drainCntNext;
  logic              stallNext, flushNext, pcLoadNext, reportHltNext;
  logic              inIsrNext, drainErrNext;
  logic [PC_W-1:0]   pcLoadValNext, savedPcNext;

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= RUN;
      drainCnt    <= '0;
      o_stall     <= 1'b0;
      o_flush     <= 1'b0;
      o_pcLoad    <= 1'b0;
      o_pcLoadVal <= '0;
      o_reportHLT <= 1'b0;
      o_inIsr     <= 1'b0;
      o_savedPC   <= '0;
      o_drainErr  <= 1'b0;
    end else begin
      state       <= stateNext;
      drainCnt    <= drainCntNext;
      o_stall     <= stallNext;
      o_flush     <= flushNext;
      o_pcLoad    <= pcLoadNext;
      o_pcLoadVal <= pcLoadValNext;
      o_reportHLT <= reportHltNext;
      o_inIsr     <= inIsrNext;
      o_savedPC   <= savedPcNext;
      o_drainErr  <= drainErrNext;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    stateNext     = state;
    drainCntNext  = drainCnt;
    flushNext     = 1'b0;
    pcLoadNext    = 1'b0;
    pcLoadValNext = o_pcLoadVal;
    reportHltNext = 1'b0;
    inIsrNext     = o_inIsr;
    savedPcNext   = o_savedPC;
    drainErrNext  = o_drainErr;

    case (state)
      RUN: begin
        drainCntNext = '0;
        if (i_haltInstr) begin
          reportHltNext = 1'b1;
          stateNext     = DRAIN_PAUSE;
        end else if (i_doPause) begin
          stateNext = DRAIN_PAUSE;
        end else if (i_intOVF && !o_inIsr) begin
          stateNext = DRAIN_INT;
        end else if (i_retI && o_inIsr && !o_pcLoad) begin
          // ~o_pcLoad keeps loads/flushes from landing on back-to-back cycles
          pcLoadNext    = 1'b1;
          pcLoadValNext = o_savedPC;
          flushNext     = 1'b1;
          inIsrNext     = 1'b0;
        end
      end

      DRAIN_PAUSE, DRAIN_INT: begin
        if (i_pipeEmpty) begin
          drainCntNext = '0;
          stateNext    = (state == DRAIN_PAUSE) ? PAUSED : VECTOR;
        end else if (drainCnt == CNT_W'(DRAIN_MAX - 1)) begin
          // Counter would reach DRAIN_MAX: flag and make forced progress
          drainCntNext = '0;
          drainErrNext = 1'b1;
          stateNext    = (state == DRAIN_PAUSE) ? PAUSED : VECTOR;
        end else begin
          drainCntNext = drainCnt + CNT_W'(1);
        end
      end

      PAUSED: begin
        if (!i_doPause) begin
          stateNext = RUN;
        end
      end

      VECTOR: begin
        savedPcNext   = i_pcCur;
        inIsrNext     = 1'b1;
        pcLoadNext    = 1'b1;
        pcLoadValNext = ISR_VECTOR;
        flushNext     = 1'b1;
        stateNext     = RUN;
      end

      default: begin
        stateNext    = RUN;
        drainCntNext = '0;
      end
    endcase

    // Stall covers every non-RUN state plus the cycle the vector load lands
    stallNext = (stateNext != RUN) || (state == VECTOR);
  end

endmodule
